// File: rtl/key_store_pkg.sv
// Shared types, default sizes and sizing helpers for the round-key store.
package key_store_pkg;

  localparam int unsigned KS_DATA_W    = 32;
  localparam int unsigned KS_DEPTH     = 64;
  localparam int unsigned KS_KEY_WORDS = 4;

  // AES round-key counts (AES-128 / AES-192 / AES-256)
  localparam int unsigned AES128_RK = 11;
  localparam int unsigned AES192_RK = 13;
  localparam int unsigned AES256_RK = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } ks_state_e;

  // Round-key capacity of the store
  function automatic int unsigned ks_nrk(input int unsigned depth, input int unsigned key_words);
    return depth / key_words;
  endfunction

  // Width able to hold a round count 0..NRK
  function automatic int unsigned ks_rnd_w(input int unsigned depth, input int unsigned key_words);
    return $clog2(ks_nrk(depth, key_words) + 1);
  endfunction

endpackage

// File: rtl/key_word_bank.sv
// Key word storage with per-word valid bits, two word read ports and one
// packed round-key read port. Optional same-cycle write forwarding under
// ROUND_KEY_STORE_BYPASS_EN.
module key_word_bank
  import key_store_pkg::*;
#(
  parameter int unsigned DATA_W    = KS_DATA_W,
  parameter int unsigned DEPTH     = KS_DEPTH,
  parameter int unsigned KEY_WORDS = KS_KEY_WORDS,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned RIDX_W    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [ADDR_W-1:0]           addr_wr_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        clear_i,
  input  logic [ADDR_W-1:0]           addr_a_i,
  input  logic [ADDR_W-1:0]           addr_b_i,
  output logic [DATA_W-1:0]           out_a_o,
  output logic [DATA_W-1:0]           out_b_o,
  input  logic [RIDX_W-1:0]           round_i,
  output logic [KEY_WORDS*DATA_W-1:0] round_key_o,
  output logic                        round_valid_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;
  logic [KEY_WORDS-1:0] word_vld;
  logic wr_hit;

  assign wr_hit = wr_en_i && (32'(addr_wr_i) < DEPTH);

  // Word data storage, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_hit) begin
      mem_q[addr_wr_i] <= data_i;
    end
  end

  // Valid bits: Clear drops all, a concurrent write wins for its own entry
  always_comb begin
    vld_d = clear_i ? '0 : vld_q;
    if (wr_hit) vld_d[addr_wr_i] = 1'b1;
  end

  // Valid bit register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Read port A
  always_comb begin
    out_a_o = '0;
    if (32'(addr_a_i) < DEPTH) out_a_o = mem_q[addr_a_i];
`ifdef ROUND_KEY_STORE_BYPASS_EN
    if (wr_hit && (addr_wr_i == addr_a_i)) out_a_o = data_i;
`endif
  end

  // Read port B
  always_comb begin
    out_b_o = '0;
    if (32'(addr_b_i) < DEPTH) out_b_o = mem_q[addr_b_i];
`ifdef ROUND_KEY_STORE_BYPASS_EN
    if (wr_hit && (addr_wr_i == addr_b_i)) out_b_o = data_i;
`endif
  end

  // Packed round-key read; word k of the round lands at bits k*DATA_W
  for (genvar k = 0; k < KEY_WORDS; k++) begin : g_word
    logic [31:0]       idx;
    logic              in_rng;
    logic [DATA_W-1:0] word_c;
    logic              vld_c;

    assign idx    = 32'(round_i) * 32'(KEY_WORDS) + 32'(k);
    assign in_rng = idx < 32'(DEPTH);

    // Select one word of the round and its valid bit
    always_comb begin
      word_c = '0;
      vld_c  = 1'b0;
      if (in_rng) begin
        word_c = mem_q[ADDR_W'(idx)];
        vld_c  = vld_q[ADDR_W'(idx)];
      end
`ifdef ROUND_KEY_STORE_BYPASS_EN
      if (wr_hit && (32'(addr_wr_i) == idx)) begin
        word_c = data_i;
        vld_c  = 1'b1;
      end
`endif
    end

    assign round_key_o[k*DATA_W +: DATA_W] = word_c;
    assign word_vld[k] = vld_c;
  end

  assign round_valid_o = &word_vld;

endmodule

// File: rtl/round_key_store.sv
// Expanded-key store with a round-key streamer (forward or reverse order,
// valid/ready output, stalls on rounds not yet written).
// Optional macro ROUND_KEY_STORE_BYPASS_EN enables write-to-read forwarding.
module round_key_store
  import key_store_pkg::*;
#(
  parameter int unsigned DATA_W    = KS_DATA_W,
  parameter int unsigned DEPTH     = KS_DEPTH,
  parameter int unsigned KEY_WORDS = KS_KEY_WORDS,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned RND_W     = ks_rnd_w(DEPTH, KEY_WORDS)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Wr_En,
  input  logic [ADDR_W-1:0]           Addr_Wr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        Clear,
  input  logic [ADDR_W-1:0]           Addr_A,
  input  logic [ADDR_W-1:0]           Addr_B,
  output logic [DATA_W-1:0]           Out_A,
  output logic [DATA_W-1:0]           Out_B,
  input  logic                        Key_Start,
  input  logic                        Key_Dir,
  input  logic [RND_W-1:0]            Key_Rounds,
  output logic [KEY_WORDS*DATA_W-1:0] Out_Key,
  output logic                        Key_Valid,
  input  logic                        Key_Ready,
  output logic                        Key_Done,
  output logic                        Busy
);

  localparam int unsigned NRK    = ks_nrk(DEPTH, KEY_WORDS);
  localparam int unsigned RIDX_W = (NRK > 1) ? $clog2(NRK) : 1;
  localparam int unsigned KEY_W  = KEY_WORDS * DATA_W;

  ks_state_e         state_q, state_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic [RND_W-1:0]  left_q, left_d;
  logic              dir_q, dir_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q;

  logic [RND_W-1:0]  n_c;
  logic [RIDX_W-1:0] nxt_round_c;
  logic [RIDX_W-1:0] look_round_c;
  logic [KEY_W-1:0]  bank_key;
  logic              bank_valid;

  assign n_c          = (32'(Key_Rounds) > NRK) ? RND_W'(NRK) : Key_Rounds;
  assign nxt_round_c  = dir_q ? (round_q - RIDX_W'(1)) : (round_q + RIDX_W'(1));
  // In SEND the bank looks ahead so the next beat can load on the handshake edge
  assign look_round_c = (state_q == ST_SEND) ? nxt_round_c : round_q;

  key_word_bank #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .KEY_WORDS (KEY_WORDS),
    .ADDR_W    (ADDR_W),
    .RIDX_W    (RIDX_W)
  ) u_bank (
    .clk_i         (Clk),
    .rst_i         (Rst),
    .wr_en_i       (Wr_En),
    .addr_wr_i     (Addr_Wr),
    .data_i        (data_in),
    .clear_i       (Clear),
    .addr_a_i      (Addr_A),
    .addr_b_i      (Addr_B),
    .out_a_o       (Out_A),
    .out_b_o       (Out_B),
    .round_i       (look_round_c),
    .round_key_o   (bank_key),
    .round_valid_o (bank_valid)
  );

  // Streamer next-state and output decode
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    left_d  = left_q;
    dir_d   = dir_q;
    key_d   = key_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Key_Start) begin
          dir_d  = Key_Dir;
          left_d = n_c;
          if (n_c == '0) begin
            done_d = 1'b1;
          end else begin
            round_d = Key_Dir ? RIDX_W'(n_c - RND_W'(1)) : '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (bank_valid) begin
          key_d   = bank_key;
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid_q && Key_Ready) begin
          left_d = left_q - RND_W'(1);
          if (left_q == RND_W'(1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            round_d = nxt_round_c;
            if (bank_valid) begin
              key_d = bank_key;
            end else begin
              valid_d = 1'b0;
              state_d = ST_FETCH;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Streamer state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      left_q  <= '0;
      dir_q   <= 1'b0;
      key_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      left_q  <= left_d;
      dir_q   <= dir_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign Out_Key   = key_q;
  assign Key_Valid = valid_q;
  assign Key_Done  = done_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: read-port vectors, a table of stream
// runs, and hand-written stall/backpressure/reset sequences.
// Expectations follow ROUND_KEY_STORE_BYPASS_EN when it is defined.
module tb_round_key_store;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned RND_W  = 5;
  localparam int unsigned KEY_W  = 128;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Wr_En;
  logic [ADDR_W-1:0] Addr_Wr;
  logic [DATA_W-1:0] data_in;
  logic              Clear;
  logic [ADDR_W-1:0] Addr_A;
  logic [ADDR_W-1:0] Addr_B;
  logic [DATA_W-1:0] Out_A;
  logic [DATA_W-1:0] Out_B;
  logic              Key_Start;
  logic              Key_Dir;
  logic [RND_W-1:0]  Key_Rounds;
  logic [KEY_W-1:0]  Out_Key;
  logic              Key_Valid;
  logic              Key_Ready;
  logic              Key_Done;
  logic              Busy;

  int checks   = 0;
  int failures = 0;

  round_key_store dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Wr_En      (Wr_En),
    .Addr_Wr    (Addr_Wr),
    .data_in    (data_in),
    .Clear      (Clear),
    .Addr_A     (Addr_A),
    .Addr_B     (Addr_B),
    .Out_A      (Out_A),
    .Out_B      (Out_B),
    .Key_Start  (Key_Start),
    .Key_Dir    (Key_Dir),
    .Key_Rounds (Key_Rounds),
    .Out_Key    (Out_Key),
    .Key_Valid  (Key_Valid),
    .Key_Ready  (Key_Ready),
    .Key_Done   (Key_Done),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
  } rd_vec_t;

  typedef struct {
    logic             dir;
    logic [RND_W-1:0] rounds;
    int               n;
    int               first_r;
    logic [KEY_W-1:0] exp_first;
  } st_vec_t;

  rd_vec_t rvec [4];
  st_vec_t svec [8];

  task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round r of a block where word i holds base+i
  function automatic logic [KEY_W-1:0] rk(input int r, input logic [31:0] base);
    logic [KEY_W-1:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = base + 32'(4*r + k);
    return v;
  endfunction

  // Called at posedge+1; performs one write on the next edge
  task automatic wr(input int addr, input logic [31:0] d);
    Wr_En   = 1'b1;
    Addr_Wr = ADDR_W'(addr);
    data_in = d;
    @(posedge Clk); #1;
    Wr_En   = 1'b0;
  endtask

  task automatic start(input logic dir, input logic [RND_W-1:0] rounds);
    Key_Dir    = dir;
    Key_Rounds = rounds;
    Key_Start  = 1'b1;
    @(posedge Clk); #1;
    Key_Start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!Key_Done && c < 20) begin
      @(posedge Clk); #1;
      c++;
    end
    chk(name, KEY_W'(Key_Done), KEY_W'(1));
    chk({name, "_busy"}, KEY_W'(Busy), KEY_W'(0));
  endtask

  task automatic run_stream(input st_vec_t v);
    int beats, cyc, first_cyc, done_cyc, r;
    Key_Ready = 1'b1;
    start(v.dir, v.rounds);
    beats = 0; cyc = 0; first_cyc = -1; done_cyc = -1;
    while (cyc < 40 && done_cyc < 0) begin
      if (Key_Valid) begin
        r = v.dir ? (v.first_r - beats) : (v.first_r + beats);
        if (beats == 0) begin
          first_cyc = cyc;
          chk("stream_first", Out_Key, v.exp_first);
        end else begin
          chk("stream_beat", Out_Key, rk(r, 32'h1000));
        end
        beats++;
      end
      if (Key_Done) done_cyc = cyc;
      else begin
        @(posedge Clk); #1;
        cyc++;
      end
    end
    chk("stream_nbeats", KEY_W'(beats), KEY_W'(v.n));
    chk("stream_done_cyc", KEY_W'(done_cyc), KEY_W'((v.n == 0) ? 0 : v.n + 1));
    if (v.n > 0) chk("stream_first_lat", KEY_W'(first_cyc), KEY_W'(1));
    chk("stream_busy_end", KEY_W'(Busy), KEY_W'(0));
  endtask

  initial begin
    bit done_seen;

    rvec[0] = '{6'd0,  6'd63, 32'h1000, 32'h103F};
    rvec[1] = '{6'd5,  6'd40, 32'h1005, 32'h1028};
    rvec[2] = '{6'd43, 6'd17, 32'h102B, 32'h1011};
    rvec[3] = '{6'd62, 6'd1,  32'h103E, 32'h1001};

    svec[0] = '{1'b0, 5'd11, 11, 0,  128'h00001003_00001002_00001001_00001000};
    svec[1] = '{1'b1, 5'd11, 11, 10, 128'h0000102B_0000102A_00001029_00001028};
    svec[2] = '{1'b0, 5'd13, 13, 0,  128'h00001003_00001002_00001001_00001000};
    svec[3] = '{1'b1, 5'd15, 15, 14, 128'h0000103B_0000103A_00001039_00001038};
    svec[4] = '{1'b0, 5'd20, 16, 0,  128'h00001003_00001002_00001001_00001000};
    svec[5] = '{1'b1, 5'd31, 16, 15, 128'h0000103F_0000103E_0000103D_0000103C};
    svec[6] = '{1'b0, 5'd0,  0,  0,  128'h0};
    svec[7] = '{1'b1, 5'd1,  1,  0,  128'h00001003_00001002_00001001_00001000};

    Rst = 1'b1; Wr_En = 1'b0; Addr_Wr = '0; data_in = '0; Clear = 1'b0;
    Addr_A = 6'd5; Addr_B = '0; Key_Start = 1'b0; Key_Dir = 1'b0;
    Key_Rounds = '0; Key_Ready = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out_a", KEY_W'(Out_A), KEY_W'(0));
    chk("rst_valid", KEY_W'(Key_Valid), KEY_W'(0));
    chk("rst_busy",  KEY_W'(Busy), KEY_W'(0));
    chk("rst_done",  KEY_W'(Key_Done), KEY_W'(0));
    chk("rst_key",   Out_Key, KEY_W'(0));
    Rst = 1'b0;
    @(posedge Clk); #1;

    // Start with nothing written: busy, never valid
    start(1'b0, 5'd1);
    repeat (5) @(posedge Clk);
    #1;
    chk("empty_busy",  KEY_W'(Busy), KEY_W'(1));
    chk("empty_valid", KEY_W'(Key_Valid), KEY_W'(0));
    Rst = 1'b1; #2; Rst = 1'b0;
    @(posedge Clk); #1;

    // Fill the store and check both read ports
    for (int i = 0; i < 64; i++) wr(i, 32'h1000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      Addr_A = rvec[i].a;
      Addr_B = rvec[i].b;
      #1;
      chk("read_a", KEY_W'(Out_A), KEY_W'(rvec[i].ea));
      chk("read_b", KEY_W'(Out_B), KEY_W'(rvec[i].eb));
    end

    // Stream table
    for (int i = 0; i < 8; i++) begin
      run_stream(svec[i]);
      @(posedge Clk); #1;
    end

    // Backpressure with Clear while a beat is held
    Key_Ready = 1'b0;
    start(1'b0, 5'd2);
    chk("bp_fetch", KEY_W'(Key_Valid), KEY_W'(0));
    @(posedge Clk); #1;
    chk("bp_valid", KEY_W'(Key_Valid), KEY_W'(1));
    chk("bp_key",   Out_Key, 128'h00001003_00001002_00001001_00001000);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) Clear = 1'b1;
      @(posedge Clk); #1;
      Clear = 1'b0;
      chk("bp_hold_valid", KEY_W'(Key_Valid), KEY_W'(1));
      chk("bp_hold_key",   Out_Key, 128'h00001003_00001002_00001001_00001000);
    end
    Key_Ready = 1'b1;
    @(posedge Clk); #1;
    chk("bp_refetch_valid", KEY_W'(Key_Valid), KEY_W'(0));
    chk("bp_refetch_busy",  KEY_W'(Busy), KEY_W'(1));
    wr(4, 32'h1004); wr(5, 32'h1005); wr(6, 32'h1006);
    wr(7, 32'h1007);
`ifndef ROUND_KEY_STORE_BYPASS_EN
    chk("bp_lat_early", KEY_W'(Key_Valid), KEY_W'(0));
    @(posedge Clk); #1;
`endif
    chk("bp_r1_valid", KEY_W'(Key_Valid), KEY_W'(1));
    chk("bp_r1_key",   Out_Key, 128'h00001007_00001006_00001005_00001004);
    wait_done("bp_done");
    @(posedge Clk); #1;

    // Clear together with a write: the written word survives
    Clear = 1'b1;
    wr(7, 32'h3007);
    Clear = 1'b0;
    wr(4, 32'h3004); wr(5, 32'h3005); wr(6, 32'h3006);
    start(1'b1, 5'd2);
    chk("cw_fetch", KEY_W'(Key_Valid), KEY_W'(0));
    @(posedge Clk); #1;
    chk("cw_valid", KEY_W'(Key_Valid), KEY_W'(1));
    chk("cw_key",   Out_Key, 128'h00003007_00003006_00003005_00003004);
    // Round 0 was cleared: stall
    @(posedge Clk); #1;
    chk("stall_valid", KEY_W'(Key_Valid), KEY_W'(0));
    repeat (3) @(posedge Clk);
    #1;
    chk("stall_busy",   KEY_W'(Busy), KEY_W'(1));
    chk("stall_valid2", KEY_W'(Key_Valid), KEY_W'(0));
    wr(0, 32'h2000); wr(1, 32'h2001); wr(2, 32'h2002);
    chk("stall_partial", KEY_W'(Key_Valid), KEY_W'(0));
    wr(3, 32'h2003);
`ifndef ROUND_KEY_STORE_BYPASS_EN
    chk("stall_lat_early", KEY_W'(Key_Valid), KEY_W'(0));
    @(posedge Clk); #1;
`endif
    chk("stall_resume_valid", KEY_W'(Key_Valid), KEY_W'(1));
    chk("stall_resume_key",   Out_Key, 128'h00002003_00002002_00002001_00002000);
    wait_done("stall_done");
    @(posedge Clk); #1;

    // Reset in the middle of a stream
    for (int i = 0; i < 64; i++) wr(i, 32'h1000 + 32'(i));
    Addr_B = 6'd10;
    start(1'b0, 5'd11);
    repeat (3) @(posedge Clk);
    #1;
    chk("mid_beat3_valid", KEY_W'(Key_Valid), KEY_W'(1));
    chk("mid_beat3_key",   Out_Key, rk(2, 32'h1000));
    Rst = 1'b1;
    #1;
    chk("mid_rst_valid", KEY_W'(Key_Valid), KEY_W'(0));
    chk("mid_rst_busy",  KEY_W'(Busy), KEY_W'(0));
    chk("mid_rst_out_b", KEY_W'(Out_B), KEY_W'(0));
    chk("mid_rst_key",   Out_Key, KEY_W'(0));
    @(posedge Clk); #1;
    Rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (Key_Done) done_seen = 1'b1;
      @(posedge Clk); #1;
    end
    chk("mid_rst_no_done", KEY_W'(done_seen), KEY_W'(0));

    // Same-cycle write and read on port A
    Addr_A  = 6'd9;
    Wr_En   = 1'b1;
    Addr_Wr = 6'd9;
    data_in = 32'hDEAD;
    #1;
`ifdef ROUND_KEY_STORE_BYPASS_EN
    chk("fwd_same_cycle", KEY_W'(Out_A), KEY_W'(32'hDEAD));
`else
    chk("nofwd_same_cycle", KEY_W'(Out_A), KEY_W'(0));
`endif
    @(posedge Clk); #1;
    Wr_En = 1'b0;
    chk("write_then_read", KEY_W'(Out_A), KEY_W'(32'hDEAD));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
